// File: rtl/ex_mem_reg_if.sv
// ---------------------------------------------------------------------------
// ex_mem_reg_if
// Bundle of everything the EX stage hands to the EX/MEM register. The ALU
// result and zero flag travel here together with the store data, the
// destination register, the control bits and the branch target.
//   master : EX stage (drives every signal)
//   slave  : ex_mem_reg (samples every signal)
// Parameter XLEN : datapath width of the result, store data and branch target.
// ---------------------------------------------------------------------------
interface ex_mem_reg_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;       // EX holds a real instruction
  logic [XLEN-1:0] alu_res;        // ALU result / memory address
  logic            alu_zero;       // ALU result == 0
  logic [XLEN-1:0] rs2_data;       // store data
  logic [4:0]      rd_addr;        // destination register
  logic            reg_write;      // instruction writes rd
  logic            mem_read;       // load
  logic            mem_write;      // store
  logic            mem_to_reg;     // writeback selects memory
  logic            branch;         // beq
  logic [XLEN-1:0] branch_target;  // PC + imm

  modport master (
    output ex_valid, alu_res, alu_zero, rs2_data, rd_addr, reg_write,
           mem_read, mem_write, mem_to_reg, branch, branch_target
  );

  modport slave (
    input  ex_valid, alu_res, alu_zero, rs2_data, rd_addr, reg_write,
           mem_read, mem_write, mem_to_reg, branch, branch_target
  );
endinterface

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
// EX/MEM pipeline register of the 5-stage RV32I core. Captures the ALU
// result, store data and control bits from EX, resolves beq from the ALU
// zero flag, issues a one-cycle PC redirect plus a FLUSH_DEPTH-cycle flush
// request to the younger stages, and provides the EX/MEM forwarding source.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   stall, flush        hazard-unit hold / bubble insert (flush wins)
//   ex_if (slave)       EX-stage signals (see ex_mem_reg_if)
//   mem_*               registered MEM-stage view, control gated by valid
//   pc_src, pc_target   redirect pulse and its address
//   flush_req           flush of IF/ID and ID/EX after a taken branch
//   fwd_valid/rd/data   forwarding source
//   stat_branches/taken only when EX_MEM_BRANCH_STATS_EN is defined:
//                       accepted-beq and taken-beq counters (wrap at 2^32)
//
// Parameters
//   XLEN         datapath width
//   FLUSH_DEPTH  cycles flush_req stays high after a taken branch (1..7)
// ---------------------------------------------------------------------------
module ex_mem_reg #(
  parameter int XLEN        = 32,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  ex_mem_reg_if.slave     ex_if,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_alu_res,
  output logic [XLEN-1:0] mem_wdata,
  output logic [4:0]      mem_rd,
  output logic            mem_reg_write,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            mem_to_reg_o,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_target,
  output logic            flush_req,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
`ifdef EX_MEM_BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken
`endif
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
  } pipe_t;

  pipe_t           pipe_d, pipe_q;
  logic            pc_src_d, pc_src_q;
  logic [XLEN-1:0] pc_target_d, pc_target_q;
  logic [2:0]      flush_cnt_d, flush_cnt_q;
  logic            take;
  logic            accept_beq;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    pipe_d      = pipe_q;
    pc_target_d = pc_target_q;
    flush_cnt_d = flush_cnt_q;

    accept_beq = ex_if.ex_valid & ex_if.branch & ~stall & ~flush;
    take       = accept_beq & ex_if.alu_zero;

    if (flush) begin
      pipe_d = '0;
    end else if (!stall) begin
      pipe_d.valid      = ex_if.ex_valid;
      pipe_d.alu_res    = ex_if.alu_res;
      pipe_d.wdata      = ex_if.rs2_data;
      pipe_d.rd         = ex_if.rd_addr;
      pipe_d.reg_write  = ex_if.reg_write  & ex_if.ex_valid;
      pipe_d.mem_read   = ex_if.mem_read   & ex_if.ex_valid;
      pipe_d.mem_write  = ex_if.mem_write  & ex_if.ex_valid;
      pipe_d.mem_to_reg = ex_if.mem_to_reg & ex_if.ex_valid;
    end

    // Redirect is a pulse: it is rebuilt from take every edge, so a single
    // branch can never hold it high for two cycles. An external flush does
    // not touch a redirect or flush count already in flight.
    pc_src_d = take;
    if (take) pc_target_d = ex_if.branch_target;

    // A new taken branch reloads the counter even if it was mid-countdown.
    if (take)                                flush_cnt_d = FLUSH_LOAD;
    else if (flush_cnt_q != '0 && !stall)    flush_cnt_d = flush_cnt_q - 3'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q      <= '0;
      pc_src_q    <= 1'b0;
      pc_target_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pipe_q      <= pipe_d;
      pc_src_q    <= pc_src_d;
      pc_target_q <= pc_target_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_valid     = pipe_q.valid;
  assign mem_alu_res   = pipe_q.alu_res;
  assign mem_wdata     = pipe_q.wdata;
  assign mem_rd        = pipe_q.rd;
  assign mem_reg_write = pipe_q.reg_write;
  assign mem_read_o    = pipe_q.mem_read;
  assign mem_write_o   = pipe_q.mem_write;
  assign mem_to_reg_o  = pipe_q.mem_to_reg;
  assign pc_src        = pc_src_q;
  assign pc_target     = pc_target_q;
  assign flush_req     = (flush_cnt_q != '0);

  // Loads have no data yet at this stage, and x0 is never a real producer.
  assign fwd_valid = pipe_q.valid & pipe_q.reg_write & (pipe_q.rd != 5'd0)
                   & ~pipe_q.mem_read;
  assign fwd_rd    = pipe_q.rd;
  assign fwd_data  = pipe_q.alu_res;

`ifdef EX_MEM_BRANCH_STATS_EN
  logic [31:0] stat_branches_d, stat_branches_q;
  logic [31:0] stat_taken_d, stat_taken_q;

  always_comb begin
    stat_branches_d = stat_branches_q + (accept_beq ? 32'd1 : 32'd0);
    stat_taken_d    = stat_taken_q    + (take       ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_taken_q    <= stat_taken_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_taken    = stat_taken_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_reg
// Self-checking bench for ex_mem_reg: a behavioural model of the EX/MEM
// register is compared against the DUT on every falling edge, and directed
// scenarios pin the model with hand-computed literal values. A randomized
// phase then exercises stall/flush/branch interactions.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ex_mem_reg;
  localparam int XLEN        = 32;
  localparam int FLUSH_DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic stall, flush;

  logic            mem_valid, mem_reg_write, mem_read_o, mem_write_o, mem_to_reg_o;
  logic [XLEN-1:0] mem_alu_res, mem_wdata, pc_target, fwd_data;
  logic [4:0]      mem_rd, fwd_rd;
  logic            pc_src, flush_req, fwd_valid;
`ifdef EX_MEM_BRANCH_STATS_EN
  logic [31:0]     stat_branches, stat_taken;
`endif

  int checks = 0;
  int errors = 0;

  ex_mem_reg_if #(.XLEN(XLEN)) ex_if ();

  ex_mem_reg #(.XLEN(XLEN), .FLUSH_DEPTH(FLUSH_DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .ex_if         (ex_if),
    .mem_valid     (mem_valid),
    .mem_alu_res   (mem_alu_res),
    .mem_wdata     (mem_wdata),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .mem_to_reg_o  (mem_to_reg_o),
    .pc_src        (pc_src),
    .pc_target     (pc_target),
    .flush_req     (flush_req),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data)
`ifdef EX_MEM_BRANCH_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_taken    (stat_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid, m_rw, m_mr, m_mw, m_m2r, m_pc_src;
  logic [31:0] m_res, m_wdata, m_target;
  logic [4:0]  m_rd;
  int          m_flush_left;
  logic [31:0] m_branches, m_taken;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_pc_src = 0;
      m_res = 0; m_wdata = 0; m_target = 0; m_rd = 0; m_flush_left = 0;
      m_branches = 0; m_taken = 0;
    end else begin
      bit acc, tk;
      acc = ex_if.ex_valid && ex_if.branch && !stall && !flush;
      tk  = acc && ex_if.alu_zero;
      if (flush) begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
        m_res = 0; m_wdata = 0; m_rd = 0;
      end else if (!stall) begin
        m_valid = ex_if.ex_valid;
        m_res   = ex_if.alu_res;
        m_wdata = ex_if.rs2_data;
        m_rd    = ex_if.rd_addr;
        m_rw    = ex_if.ex_valid && ex_if.reg_write;
        m_mr    = ex_if.ex_valid && ex_if.mem_read;
        m_mw    = ex_if.ex_valid && ex_if.mem_write;
        m_m2r   = ex_if.ex_valid && ex_if.mem_to_reg;
      end
      m_pc_src = tk;
      if (tk) m_target = ex_if.branch_target;
      if (tk) m_flush_left = FLUSH_DEPTH;
      else if (m_flush_left > 0 && !stall) m_flush_left--;
      if (acc) m_branches++;
      if (tk)  m_taken++;
    end
  end

  // Single compare process: every falling edge, every output.
  always @(negedge clk) begin
    check("mem_valid",     32'(mem_valid),     32'(m_valid));
    check("mem_alu_res",   mem_alu_res,        m_res);
    check("mem_wdata",     mem_wdata,          m_wdata);
    check("mem_rd",        32'(mem_rd),        32'(m_rd));
    check("mem_reg_write", 32'(mem_reg_write), 32'(m_rw));
    check("mem_read_o",    32'(mem_read_o),    32'(m_mr));
    check("mem_write_o",   32'(mem_write_o),   32'(m_mw));
    check("mem_to_reg_o",  32'(mem_to_reg_o),  32'(m_m2r));
    check("pc_src",        32'(pc_src),        32'(m_pc_src));
    check("pc_target",     pc_target,          m_target);
    check("flush_req",     32'(flush_req),     32'(m_flush_left != 0));
    check("fwd_valid",     32'(fwd_valid),     32'(m_valid && m_rw && m_rd != 0 && !m_mr));
    check("fwd_rd",        32'(fwd_rd),        32'(m_rd));
    check("fwd_data",      fwd_data,           m_res);
`ifdef EX_MEM_BRANCH_STATS_EN
    check("stat_branches", stat_branches,      m_branches);
    check("stat_taken",    stat_taken,         m_taken);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input bit v, input logic [31:0] res, input bit z,
                        input logic [4:0] rd, input bit rw, input bit mr,
                        input bit mw, input bit br, input logic [31:0] tgt,
                        input bit st, input bit fl);
    ex_if.ex_valid      = v;
    ex_if.alu_res       = res;
    ex_if.alu_zero      = z;
    ex_if.rs2_data      = $urandom;
    ex_if.rd_addr       = rd;
    ex_if.reg_write     = rw;
    ex_if.mem_read      = mr;
    ex_if.mem_write     = mw;
    ex_if.mem_to_reg    = mr;
    ex_if.branch        = br;
    ex_if.branch_target = tgt;
    stall               = st;
    flush               = fl;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance past the next rising edge; outputs are then settled.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int high;
    rst_n = 1'b0;
    idle();
    tick(); tick();
    check("reset mem_valid", 32'(mem_valid), 32'd0);
    check("reset flush_req", 32'(flush_req), 32'd0);
    check("reset pc_src",    32'(pc_src),    32'd0);
    rst_n = 1'b1;

    // ALU add path
    set_in(1, 32'h9, 0, 5'd5, 1, 0, 0, 0, 0, 0, 0);
    tick();
    check("add mem_alu_res", mem_alu_res, 32'h9);
    check("add mem_rd",      32'(mem_rd), 32'd5);
    check("add fwd_valid",   32'(fwd_valid), 32'd1);
    check("add fwd_data",    fwd_data, 32'h9);

    // Stall with new inputs holds
    set_in(1, 32'h77, 0, 5'd6, 1, 0, 0, 0, 0, 1, 0);
    tick();
    check("stall hold res", mem_alu_res, 32'h9);
    check("stall hold rd",  32'(mem_rd), 32'd5);

    // Store, then stall+flush together
    set_in(1, 32'h100, 0, 5'd0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    check("store mem_write_o", 32'(mem_write_o), 32'd1);
    set_in(1, 32'h104, 0, 5'd0, 0, 0, 1, 0, 0, 1, 1);
    tick();
    check("stall+flush mem_valid",   32'(mem_valid),   32'd0);
    check("stall+flush mem_write_o", 32'(mem_write_o), 32'd0);

    // Load never forwards
    set_in(1, 32'h200, 0, 5'd3, 1, 1, 0, 0, 0, 0, 0);
    tick();
    check("load fwd_valid",  32'(fwd_valid),  32'd0);
    check("load mem_read_o", 32'(mem_read_o), 32'd1);

    // rd = x0 write passes but does not forward
    set_in(1, 32'h5, 0, 5'd0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    check("x0 fwd_valid",     32'(fwd_valid),     32'd0);
    check("x0 mem_reg_write", 32'(mem_reg_write), 32'd1);

    // Taken beq: one-cycle redirect, FLUSH_DEPTH cycles of flush_req
    set_in(1, 32'h0, 1, 5'd0, 0, 0, 0, 1, 32'h40, 0, 0);
    tick();
    check("take pc_src",    32'(pc_src),    32'd1);
    check("take pc_target", pc_target,      32'h40);
    check("take flush_req1", 32'(flush_req), 32'd1);
    idle();
    tick();
    check("take pc_src off", 32'(pc_src),    32'd0);
    check("take flush_req2", 32'(flush_req), 32'd1);
    check("pc_target holds", pc_target,      32'h40);
    tick();
    check("take flush_req3", 32'(flush_req), 32'd0);

    // Not-taken beq
    set_in(1, 32'h3, 0, 5'd0, 0, 0, 0, 1, 32'h80, 0, 0);
    tick();
    check("nt pc_src",    32'(pc_src),    32'd0);
    check("nt flush_req", 32'(flush_req), 32'd0);

    // Stall during flush_req stretches it by the stall length (3)
    set_in(1, 32'h0, 1, 5'd0, 0, 0, 0, 1, 32'hC0, 0, 0);
    high = 0;
    tick();
    if (flush_req) high++;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (flush_req) high++;
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (flush_req) high++;
    end
    check("stall-stretched flush_req cycles", 32'(high), 32'd5);

    // Reset mid-run takes effect without a clock edge
    set_in(1, 32'h1234, 0, 5'd7, 1, 0, 0, 0, 0, 0, 0);
    tick();
    check("pre-reset mem_alu_res", mem_alu_res, 32'h1234);
    rst_n = 1'b0;
    #1;
    check("async reset mem_alu_res", mem_alu_res, 32'h0);
    check("async reset mem_valid",   32'(mem_valid), 32'd0);
    check("async reset fwd_valid",   32'(fwd_valid), 32'd0);
    tick();
    rst_n = 1'b1;

    // Three beqs, one taken, counted from reset
    set_in(1, 32'h1, 0, 5'd0, 0, 0, 0, 1, 32'h10, 0, 0); tick();
    set_in(1, 32'h0, 1, 5'd0, 0, 0, 0, 1, 32'h20, 0, 0); tick();
    set_in(1, 32'h2, 0, 5'd0, 0, 0, 0, 1, 32'h30, 0, 0); tick();
    idle(); tick();
`ifdef EX_MEM_BRANCH_STATS_EN
    check("stat_branches literal", stat_branches, 32'd3);
    check("stat_taken literal",    stat_taken,    32'd1);
`endif

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom,
             $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      tick();
    end
    idle();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
